// File: rtl/core_run_ctrl.sv
// core_run_ctrl: host-side sequencer for the core req/done run handshake.
// Preloads data memory, resets and starts the core, times it, reads results back.
module core_run_ctrl #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4096,
    parameter int RST_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] preload_len,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W-1:0] rd_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              mem_sel,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              core_reset,
    output logic              core_req,
    input  logic              core_done,
    output logic              rb_valid,
    output logic [DATA_W-1:0] rb_data,
    input  logic              rb_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  run_cycles,
    output logic              timed_out,
    output logic              finished
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CORE_RST,
        REQ,
        RUN,
        READBACK,
        FIN
    } state_t;

    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] RST_LAST = ADDR_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] pl_len;
    logic [ADDR_W-1:0] rb_base;
    logic [ADDR_W-1:0] rb_len;

    // Next-state decode; done takes priority over the timeout check.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (start)
                    nxt = (preload_len != '0) ? LOAD : CORE_RST;
            end
            LOAD: begin
                if (ld_valid && idx == pl_len - ONE)
                    nxt = CORE_RST;
            end
            CORE_RST: begin
                if (idx == RST_LAST)
                    nxt = REQ;
            end
            REQ: nxt = RUN;
            RUN: begin
                if (core_done)
                    nxt = (rb_len != '0) ? READBACK : FIN;
                else if (run_cycles == TO_LAST)
                    nxt = FIN;
            end
            READBACK: begin
                if (rb_ready && idx == rb_len - ONE)
                    nxt = FIN;
            end
            FIN: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State register with per-state control flags registered from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            ld_ready   <= 1'b0;
            mem_sel    <= 1'b0;
            core_reset <= 1'b0;
            core_req   <= 1'b0;
            rb_valid   <= 1'b0;
            finished   <= 1'b0;
        end else begin
            state      <= nxt;
            busy       <= (nxt != IDLE);
            ld_ready   <= (nxt == LOAD);
            mem_sel    <= (nxt == LOAD) || (nxt == READBACK);
            core_reset <= (nxt == CORE_RST);
            core_req   <= (nxt == REQ);
            rb_valid   <= (nxt == READBACK);
            finished   <= (nxt == FIN);
        end
    end

    // Shared index: load address, reset-hold count, readback offset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (nxt != state) begin
            idx <= '0;
        end else if ((state == LOAD && ld_valid) ||
                     (state == CORE_RST) ||
                     (state == READBACK && rb_ready)) begin
            idx <= idx + ONE;
        end
    end

    // Latched run parameters and run statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pl_len     <= '0;
            rb_base    <= '0;
            rb_len     <= '0;
            run_cycles <= '0;
            timed_out  <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                pl_len     <= preload_len;
                rb_base    <= rd_base;
                rb_len     <= rd_len;
                run_cycles <= '0;
                timed_out  <= 1'b0;
            end
            if (state == RUN) begin
                run_cycles <= run_cycles + CNT_W'(1);
                if (!core_done && run_cycles == TO_LAST)
                    timed_out <= 1'b1;
            end
        end
    end

    // Memory port is driven only in LOAD and READBACK; zero otherwise.
    assign mem_wr_en   = ld_ready & ld_valid;
    assign mem_wr_data = ld_ready ? ld_data : '0;
    assign mem_addr    = ld_ready ? idx :
                         rb_valid ? (rb_base + idx) : '0;
    assign rb_data     = rb_valid ? mem_rd_data : '0;

endmodule
